// File: rtl/sequenciador_sensores.sv
// Round-robin scheduler that shares one HC-SR04 interface between two ultrasonic
// sensors: trigger, wait for done or timeout, store the result, then observe a gap.
module sequenciador_sensores #(
    parameter int W         = 12,
    parameter int CW        = 22,
    parameter int T_TIMEOUT = 2500000,
    parameter int T_ESPERA  = 3000000
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         ligar,
    input  logic         pronto_if,
    input  logic [W-1:0] medida_if,
    output logic         medir,
    output logic         sel,
    output logic [W-1:0] distancia0,
    output logic [W-1:0] distancia1,
    output logic [1:0]   valido,
    output logic [1:0]   erro,
    output logic         nova_medida,
    output logic [3:0]   db_estado
);

    // Interface handshake: medir is a single-cycle start pulse; pronto_if is a
    // single-cycle done pulse, and medida_if is only meaningful while it is high.
    // There is no backpressure: a pronto_if outside AGUARDA is simply dropped.

    typedef enum logic [3:0] {
        INICIAL   = 4'd0,
        DISPARA   = 4'd1,
        AGUARDA   = 4'd2,
        REGISTRA  = 4'd3,
        ERRO      = 4'd4,
        INTERVALO = 4'd5,
        PROXIMO   = 4'd6
    } estado_t;

    localparam logic [CW-1:0] FIM_TIMEOUT = CW'(T_TIMEOUT - 1);
    localparam logic [CW-1:0] FIM_ESPERA  = CW'(T_ESPERA - 1);

    // Both intervals must be representable by the cycle counter.
    if (T_TIMEOUT < 1 || 64'(T_TIMEOUT) > (64'd1 << CW)) begin : g_chk_timeout
        $error("T_TIMEOUT does not fit in CW bits");
    end
    if (T_ESPERA < 1 || 64'(T_ESPERA) > (64'd1 << CW)) begin : g_chk_espera
        $error("T_ESPERA does not fit in CW bits");
    end

    estado_t       estado;
    logic [CW-1:0] contador;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado      <= INICIAL;
            contador    <= '0;
            medir       <= 1'b0;
            sel         <= 1'b0;
            distancia0  <= '0;
            distancia1  <= '0;
            valido      <= 2'b00;
            erro        <= 2'b00;
            nova_medida <= 1'b0;
        end else begin
            medir       <= 1'b0;
            nova_medida <= 1'b0;
            case (estado)
                INICIAL: begin
                    contador <= '0;
                    if (ligar) begin
                        estado <= DISPARA;
                        medir  <= 1'b1;
                    end
                end
                DISPARA: begin
                    contador <= '0;
                    estado   <= AGUARDA;
                end
                AGUARDA: begin
                    contador <= contador + CW'(1);
                    // A done pulse on the final timeout cycle still counts as good.
                    if (pronto_if) begin
                        if (sel) distancia1 <= medida_if;
                        else     distancia0 <= medida_if;
                        estado      <= REGISTRA;
                        nova_medida <= 1'b1;
                    end else if (contador == FIM_TIMEOUT) begin
                        estado      <= ERRO;
                        nova_medida <= 1'b1;
                    end
                end
                REGISTRA: begin
                    valido[sel] <= 1'b1;
                    erro[sel]   <= 1'b0;
                    contador    <= '0;
                    estado      <= INTERVALO;
                end
                ERRO: begin
                    valido[sel] <= 1'b0;
                    erro[sel]   <= 1'b1;
                    contador    <= '0;
                    estado      <= INTERVALO;
                end
                INTERVALO: begin
                    contador <= contador + CW'(1);
                    if (contador == FIM_ESPERA) begin
                        estado <= PROXIMO;
                    end
                end
                PROXIMO: begin
                    sel      <= ~sel;
                    contador <= '0;
                    if (ligar) begin
                        estado <= DISPARA;
                        medir  <= 1'b1;
                    end else begin
                        estado <= INICIAL;
                    end
                end
                default: begin
                    contador <= '0;
                    estado   <= INICIAL;
                end
            endcase
        end
    end

    always_comb begin
        db_estado = 4'hE;
        case (estado)
            INICIAL:   db_estado = 4'd0;
            DISPARA:   db_estado = 4'd1;
            AGUARDA:   db_estado = 4'd2;
            REGISTRA:  db_estado = 4'd3;
            ERRO:      db_estado = 4'd4;
            INTERVALO: db_estado = 4'd5;
            PROXIMO:   db_estado = 4'd6;
            default:   db_estado = 4'hE;
        endcase
    end

endmodule

// File: tb/tb_sequenciador_sensores.sv
// Directed bench for sequenciador_sensores: completed attempts are checked
// against an expected-record queue, timing and reset behaviour inline.
module tb_sequenciador_sensores;

    localparam int W = 12;

    logic         clock;
    logic         reset;
    logic         ligar;
    logic         pronto_if;
    logic [W-1:0] medida_if;
    logic         medir;
    logic         sel;
    logic [W-1:0] distancia0;
    logic [W-1:0] distancia1;
    logic [1:0]   valido;
    logic [1:0]   erro;
    logic         nova_medida;
    logic [3:0]   db_estado;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int t_prev = 0;

    // Record: {sel, distancia0, distancia1, valido, erro}
    logic [28:0] exp_q[$];

    sequenciador_sensores #(
        .W(W), .CW(22), .T_TIMEOUT(8), .T_ESPERA(4)
    ) dut (
        .clock(clock), .reset(reset), .ligar(ligar),
        .pronto_if(pronto_if), .medida_if(medida_if),
        .medir(medir), .sel(sel),
        .distancia0(distancia0), .distancia1(distancia1),
        .valido(valido), .erro(erro),
        .nova_medida(nova_medida), .db_estado(db_estado)
    );

    // clock / reset block
    initial clock = 1'b0;
    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    function automatic logic [28:0] rec(input logic s, input logic [11:0] d0,
                                        input logic [11:0] d1, input logic [1:0] v,
                                        input logic [1:0] e);
        return {s, d0, d1, v, e};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_medir(input int max, input string tag);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < max; i++) begin
            @(negedge clock);
            if (medir === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        chk({tag, "_medir_seen"}, 32'(ok), 32'd1);
    endtask

    task automatic idle_cycle();
        @(negedge clock);
        pronto_if = 1'b0;
        medida_if = W'($urandom_range(0, 4095));
    endtask

    // scoreboard: one record per concluded attempt, compared one cycle after nova_medida
    initial begin
        forever begin
            @(negedge clock);
            if (nova_medida === 1'b1) begin
                @(negedge clock);
                chk("fila_nao_vazia", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0) begin
                    chk("registro", 32'({sel, distancia0, distancia1, valido, erro}),
                        32'(exp_q.pop_front()));
                end
            end
        end
    end

    initial begin
        bit seen;
        reset     = 1'b0;
        ligar     = 1'b1;
        pronto_if = 1'b0;
        medida_if = '0;

        // 1: reset values, then INICIAL -> DISPARA with a single medir pulse
        repeat (3) @(negedge clock);
        chk("rst_estado", 32'(db_estado), 32'd0);
        chk("rst_saidas", 32'({medir, sel, distancia0, distancia1, valido, erro, nova_medida}), 32'd0);
        reset = 1'b1;
        chk("inicial", 32'(db_estado), 32'd0);
        @(negedge clock);
        chk("dispara_estado", 32'(db_estado), 32'd1);
        chk("dispara_medir", 32'({medir, sel}), 32'b10);
        t_prev = cyc;

        // 2: good reading on sensor 0 in the 3rd AGUARDA cycle
        idle_cycle();
        chk("aguarda_medir", 32'({medir, db_estado}), 32'h02);
        idle_cycle();
        idle_cycle();
        pronto_if = 1'b1;
        medida_if = 12'h123;
        exp_q.push_back(rec(1'b0, 12'h123, 12'h000, 2'b01, 2'b00));
        idle_cycle();
        chk("registra_estado", 32'({nova_medida, db_estado}), 32'h13);
        wait_medir(20, "p2");
        chk("p2_periodo", 32'(cyc - t_prev), 32'd10);
        chk("p2_sel", 32'(sel), 32'd1);
        t_prev = cyc;

        // 3: sensor 1 never answers -> timeout
        exp_q.push_back(rec(1'b1, 12'h123, 12'h000, 2'b01, 2'b10));
        wait_medir(25, "p3");
        chk("p3_periodo", 32'(cyc - t_prev), 32'd15);
        chk("p3_sel", 32'(sel), 32'd0);
        t_prev = cyc;

        // 4: pronto_if on the last timeout cycle wins; spurious pulse in the gap ignored
        repeat (8) idle_cycle();
        pronto_if = 1'b1;
        medida_if = 12'h045;
        exp_q.push_back(rec(1'b0, 12'h045, 12'h000, 2'b01, 2'b10));
        idle_cycle();
        chk("limite_registra", 32'(db_estado), 32'd3);
        idle_cycle();
        chk("intervalo", 32'(db_estado), 32'd5);
        pronto_if = 1'b1;
        medida_if = 12'hFFF;
        idle_cycle();
        idle_cycle();
        chk("espurio_dist", 32'({distancia0, distancia1}), 32'h045000);
        wait_medir(20, "p4");
        chk("p4_periodo", 32'(cyc - t_prev), 32'd15);
        chk("p4_sel", 32'(sel), 32'd1);

        // 5: ligar dropped mid-attempt -> finish, toggle sel, park in INICIAL
        idle_cycle();
        ligar = 1'b0;
        idle_cycle();
        pronto_if = 1'b1;
        medida_if = 12'h789;
        exp_q.push_back(rec(1'b1, 12'h045, 12'h789, 2'b11, 2'b00));
        idle_cycle();
        seen = 1'b0;
        for (int i = 0; i < 15; i++) begin
            idle_cycle();
            if (medir === 1'b1) seen = 1'b1;
        end
        chk("parado_sem_medir", 32'(seen), 32'd0);
        chk("parado_estado", 32'({sel, db_estado}), 32'h00);
        chk("parado_flags", 32'({valido, erro}), 32'b1100);
        ligar = 1'b1;
        wait_medir(5, "p5");
        chk("p5_sel", 32'(sel), 32'd0);

        // 6: async reset during INTERVALO clears everything immediately
        idle_cycle();
        pronto_if = 1'b1;
        medida_if = 12'h321;
        exp_q.push_back(rec(1'b0, 12'h321, 12'h789, 2'b11, 2'b00));
        idle_cycle();
        idle_cycle();
        idle_cycle();
        chk("p6_intervalo", 32'(db_estado), 32'd5);
        #2 reset = 1'b0;
        #1;
        chk("rst_async_estado", 32'(db_estado), 32'd0);
        chk("rst_async_saidas", 32'({medir, sel, distancia0, distancia1, valido, erro, nova_medida}), 32'd0);
        ligar = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b1;
        repeat (2) @(negedge clock);
        chk("fila_final", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sequenciador_sensores.md
Name: sequenciador_sensores

Overview:
- Scheduler that shares one HC-SR04 interface (trigger generator and echo timer) between two ultrasonic sensors in round-robin order.
- For each sensor it selects the trigger/echo mux, pulses the interface start, and waits for the interface done flag or a timeout.
- It stores the distance per sensor, then enforces an inter-measurement gap before serving the other sensor.
- It sits between the cargo-control logic, which reads distances and flags, and the interface, whose outputs are muxed by `sel`.

Parameters:
- W, 12, width of the distance word from the interface (3 BCD digits).
- CW, 22, width of the internal cycle counter.
- T_TIMEOUT, 2500000, cycles allowed from `medir` to `pronto_if` before declaring a timeout (50 ms at 50 MHz).
- T_ESPERA, 3000000, gap cycles after each measurement before the next trigger (60 ms at 50 MHz).

Ports:
- clock  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-low reset; 0 = reset asserted.
- ligar  in  1  level enable for continuous round-robin measuring.
- pronto_if  in  1  1-cycle done pulse from the interface.
- medida_if  in  W  distance from the interface; valid while `pronto_if`=1.
- medir  out  1  1-cycle start pulse to the interface.
- sel  out  1  active sensor index; drives the trigger/echo mux.
- distancia0  out  W  last good distance, sensor 0.
- distancia1  out  W  last good distance, sensor 1.
- valido  out  2  bit i=1: `distancia<i>` holds a measurement from the latest attempt on sensor i.
- erro  out  2  bit i=1: latest attempt on sensor i timed out.
- nova_medida  out  1  1-cycle pulse when an attempt concludes, good or timeout.
- db_estado  out  4  state code for the 7-segment debug display.

Behaviour:
- Reset (`reset`=0, async): state INICIAL; `medir`=0, `sel`=0, `distancia0`=`distancia1`=0, `valido`=00, `erro`=00, `nova_medida`=0, counter=0.
- Moore FSM. All outputs are registered or decoded from the state; no output depends combinationally on inputs.
- db_estado codes: INICIAL=0, DISPARA=1, AGUARDA=2, REGISTRA=3, ERRO=4, INTERVALO=5, PROXIMO=6, illegal=4'hE.
- INICIAL: counter=0. Go to DISPARA when `ligar`=1; otherwise stay.
- DISPARA: `medir`=1 for exactly this one cycle; counter cleared. Always go to AGUARDA.
- AGUARDA: counter increments each cycle.
  - `pronto_if`=1 → REGISTRA.
  - Else counter==T_TIMEOUT-1 → ERRO.
  - Both in the same cycle: `pronto_if` wins.
- REGISTRA: `distancia[sel]`<=`medida_if` captured on the cycle `pronto_if` was seen. Implement by registering in AGUARDA when `pronto_if`=1, so no value can be lost. Also `valido[sel]`<=1, `erro[sel]`<=0, `nova_medida`=1. Go to INTERVALO with counter cleared.
- ERRO: `valido[sel]`<=0, `erro[sel]`<=1; `distancia[sel]` holds its old value; `nova_medida`=1. Go to INTERVALO with counter cleared.
- INTERVALO: counter increments; at counter==T_ESPERA-1 go to PROXIMO. `pronto_if` is ignored here (late or spurious pulses are discarded).
- PROXIMO: `sel`<=~`sel`. If `ligar`=1 go to DISPARA, else INICIAL.
- `ligar` deasserted mid-sequence: the current attempt completes through INTERVALO and PROXIMO, then the FSM parks in INICIAL. Stored distances and flags are retained; `sel` keeps its toggled value, and the next enable resumes with the other sensor.
- The other sensor's `distancia`/`valido`/`erro` bits are never modified during an attempt on `sel`.
- Timing:
  - Trigger-to-trigger period with a good reading = 1 (DISPARA) + k (AGUARDA, `pronto_if` in the k-th AGUARDA cycle) + 1 + T_ESPERA + 1 cycles.
  - Timeout period = 1 + T_TIMEOUT + 1 + T_ESPERA + 1 cycles.
- Counter: CW bits, unsigned. Synthesis must check T_TIMEOUT and T_ESPERA ≤ 2^CW.
- Illegal state codes recover to INICIAL on the next clock.
- Reset asserted mid-operation: immediate return to reset values, including clearing stored distances.

Test Plan (T_TIMEOUT=8, T_ESPERA=4, W=12):
1. Reset=0 with `ligar`=1, then release → INICIAL for one cycle, DISPARA next; `medir`=1 for exactly 1 cycle; `sel`=0; outputs 0 before the first trigger.
2. `pronto_if` pulse with `medida_if`=12'h123, 3 cycles after `medir` → `distancia0`=123, `valido`=01, `erro`=00, one `nova_medida` pulse. After 4 gap cycles plus PROXIMO, the next `medir` occurs with `sel`=1.
3. Sensor 1: no `pronto_if` → ERRO after 8 AGUARDA cycles; `erro`=10, `valido`=01, `distancia1`=0. Then `sel` returns to 0.
4. `pronto_if` on the same cycle the counter reaches 7 (`medida_if`=12'h045) → REGISTRA taken; `distancia`=045, `erro` bit 0. A spurious `pronto_if` during INTERVALO → no register change.
5. `ligar`→0 while in AGUARDA → attempt finishes, PROXIMO, parks in INICIAL (db_estado=0), no further `medir`. Re-assert `ligar` → next trigger uses the toggled `sel`.
6. Reset pulled low during INTERVALO after stored readings → all outputs return to reset values immediately (async), `db_estado`=0.
